// File: rtl/ysyx_040750_pipe_pkg.sv
// Shared pipeline definitions for the hazard controller and its comparators.
// A shadow slot is a small record of one in-flight instruction: whether it is
// real, which register it writes, and whether it is a load.
package ysyx_040750_pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wen;
        logic                  isLoad;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // A slot commits a register write only if it holds a real instruction
    function automatic logic slotWritesReg(input slot_t s);
        return s.valid & s.wen;
    endfunction

endpackage

// File: rtl/ysyx_040750_hazard_match.sv
// Per-stage source/destination comparator. Reports, for the instruction in ID,
// whether rs1 ([1]) and rs2 ([0]) are produced by the instruction in this slot.
// x0 is hardwired to zero, so a slot writing x0 never matches.
module ysyx_040750_hazard_match
    import ysyx_040750_pipe_pkg::*;
(
    input  slot_t                 i_slot,
    input  logic [REG_ADDR_W-1:0] i_rs1Addr,
    input  logic [REG_ADDR_W-1:0] i_rs2Addr,
    input  logic                  i_rs1Used,
    input  logic                  i_rs2Used,
    output logic [1:0]            o_match
);

    logic w_producer;
    logic w_unusedIsLoad;

    // The load flag only matters for the load-use check in the parent
    assign w_unusedIsLoad = i_slot.isLoad;

    assign w_producer = slotWritesReg(i_slot) & (i_slot.rd != '0);

    assign o_match[1] = w_producer & (i_slot.rd == i_rs1Addr) & i_rs1Used;
    assign o_match[0] = w_producer & (i_slot.rd == i_rs2Addr) & i_rs2Used;

endmodule

// File: rtl/ysyx_040750_hazard_ctrl.sv
// Pipeline hazard controller. Shadows the EX/MEM/WB stages with three slots,
// drives forward-select match bits, load-use stall/bubble, global hold for
// multicycle ALU ops and slow memory, and counts stalled fetch cycles.
module ysyx_040750_hazard_ctrl
    import ysyx_040750_pipe_pkg::*;
(
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_ID_valid,
    input  logic [REG_ADDR_W-1:0] I_ID_rs1_addr,
    input  logic [REG_ADDR_W-1:0] I_ID_rs2_addr,
    input  logic                  I_ID_rs1_used,
    input  logic                  I_ID_rs2_used,
    input  logic [REG_ADDR_W-1:0] I_ID_rd_addr,
    input  logic                  I_ID_reg_wen,
    input  logic                  I_ID_is_load,
    input  logic                  I_EX_busy,
    input  logic                  I_mem_ready,
    input  logic                  I_flush,
    output logic [1:0]            O_EX_stall,
    output logic [1:0]            O_MEM_stall,
    output logic [1:0]            O_WB_stall,
    output logic                  O_EX_reg_wen,
    output logic                  O_MEM_reg_wen,
    output logic                  O_WB_reg_wen,
    output logic                  O_IF_ID_stall,
    output logic                  O_ID_EX_bubble,
    output logic                  O_pipe_hold,
    output logic [CNT_W-1:0]      O_stall_cnt
);

    slot_t            r_eSlot;
    slot_t            r_mSlot;
    slot_t            r_wSlot;
    logic [CNT_W-1:0] r_stallCnt;

    slot_t            w_idSlot;
    logic [1:0]       w_exMatch;
    logic [1:0]       w_memMatch;
    logic [1:0]       w_wbMatch;
    logic             w_memWait;
    logic             w_pipeHold;
    logic             w_loadUse;
    logic             w_ifIdStall;
    logic             w_idExBubble;

    assign w_idSlot = '{valid:  I_ID_valid,
                        rd:     I_ID_rd_addr,
                        wen:    I_ID_reg_wen,
                        isLoad: I_ID_is_load};

    ysyx_040750_hazard_match u_matchEx (
        .i_slot    (r_eSlot),
        .i_rs1Addr (I_ID_rs1_addr),
        .i_rs2Addr (I_ID_rs2_addr),
        .i_rs1Used (I_ID_rs1_used),
        .i_rs2Used (I_ID_rs2_used),
        .o_match   (w_exMatch)
    );

    ysyx_040750_hazard_match u_matchMem (
        .i_slot    (r_mSlot),
        .i_rs1Addr (I_ID_rs1_addr),
        .i_rs2Addr (I_ID_rs2_addr),
        .i_rs1Used (I_ID_rs1_used),
        .i_rs2Used (I_ID_rs2_used),
        .o_match   (w_memMatch)
    );

    ysyx_040750_hazard_match u_matchWb (
        .i_slot    (r_wSlot),
        .i_rs1Addr (I_ID_rs1_addr),
        .i_rs2Addr (I_ID_rs2_addr),
        .i_rs1Used (I_ID_rs1_used),
        .i_rs2Used (I_ID_rs2_used),
        .o_match   (w_wbMatch)
    );

    // Hold the whole pipe while the multicycle ALU works or a load in MEM waits
    assign w_memWait  = r_mSlot.valid & r_mSlot.isLoad & ~I_mem_ready;
    assign w_pipeHold = I_EX_busy | w_memWait;

    // A load in EX whose result ID needs cannot be forwarded yet; the EX match
    // already folds in valid, wen, rd!=0 and the used bits
    assign w_loadUse = I_ID_valid & r_eSlot.isLoad & (|w_exMatch);

    // A flush discards the ID instruction, so it overrides the load-use freeze;
    // during a hold nothing moves, so neither flush nor bubble takes effect
    assign w_ifIdStall  = w_pipeHold | (w_loadUse & ~I_flush);
    assign w_idExBubble = ~w_pipeHold & (I_flush | w_loadUse);

    // Advance the shadow slots alongside the real pipeline registers
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_eSlot <= SLOT_EMPTY;
            r_mSlot <= SLOT_EMPTY;
            r_wSlot <= SLOT_EMPTY;
        end else if (!w_pipeHold) begin
            r_wSlot <= r_mSlot;
            r_mSlot <= r_eSlot;
            r_eSlot <= w_idExBubble ? SLOT_EMPTY : w_idSlot;
        end
    end

    // Count cycles where fetch is frozen, sticking at all-ones
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_stallCnt <= '0;
        end else if (w_ifIdStall && (r_stallCnt != {CNT_W{1'b1}})) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign O_EX_stall     = w_exMatch;
    assign O_MEM_stall    = w_memMatch;
    assign O_WB_stall     = w_wbMatch;
    assign O_EX_reg_wen   = slotWritesReg(r_eSlot);
    assign O_MEM_reg_wen  = slotWritesReg(r_mSlot);
    assign O_WB_reg_wen   = slotWritesReg(r_wSlot);
    assign O_IF_ID_stall  = w_ifIdStall;
    assign O_ID_EX_bubble = w_idExBubble;
    assign O_pipe_hold    = w_pipeHold;
    assign O_stall_cnt    = r_stallCnt;

endmodule
